// File: rtl/dual_port_ram.sv
// Dual-port byte-enable RAM with a built-in zero-clear engine; reads are registered (latency 1).
// No backpressure: port accesses are dropped while busy (clear in progress), clr is ignored while busy.
module dual_port_ram #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 16,
  parameter int RD_MODE = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en_a,
  input  logic                     we_a,
  input  logic [WIDTH/8-1:0]       be_a,
  input  logic [$clog2(DEPTH)-1:0] addr_a,
  input  logic [WIDTH-1:0]         din_a,
  output logic [WIDTH-1:0]         dout_a,
  output logic                     vld_a,
  input  logic                     en_b,
  input  logic                     we_b,
  input  logic [WIDTH/8-1:0]       be_b,
  input  logic [$clog2(DEPTH)-1:0] addr_b,
  input  logic [WIDTH-1:0]         din_b,
  output logic [WIDTH-1:0]         dout_b,
  output logic                     vld_b,
  input  logic                     clr,
  output logic                     busy,
  output logic                     coll
);

  localparam int NB = WIDTH / 8;
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   ptr, ptr_nxt;
  logic            acc_ok;
  logic [WIDTH-1:0] mem [DEPTH];

  logic            wr_a, rd_a, wr_b, rd_b, same_addr;
  logic [NB-1:0]   mask_b;
  logic [WIDTH-1:0] cur_a, cur_b, new_a, new_b;

  // Controller: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Controller: next state
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      CLEAR: begin
        if (ptr == AW'(DEPTH - 1)) begin
          state_nxt = IDLE;
          ptr_nxt   = '0;
        end else begin
          ptr_nxt = ptr + AW'(1);
        end
      end
      IDLE: begin
        if (clr) begin
          state_nxt = CLEAR;
          ptr_nxt   = '0;
        end
      end
      default: begin
        state_nxt = CLEAR;
        ptr_nxt   = '0;
      end
    endcase
  end

  // Controller: outputs
  always_comb begin
    busy   = (state == CLEAR);
    acc_ok = (state == IDLE);
  end

  // Port decode; on a same-address dual write port A owns every byte it enables
  always_comb begin
    wr_a      = acc_ok & en_a & we_a;
    rd_a      = acc_ok & en_a & ~we_a;
    wr_b      = acc_ok & en_b & we_b;
    rd_b      = acc_ok & en_b & ~we_b;
    same_addr = (addr_a == addr_b);
    cur_a     = mem[addr_a];
    cur_b     = mem[addr_b];
    mask_b    = '0;
    new_a     = '0;
    new_b     = '0;
    for (int k = 0; k < NB; k++) begin
      mask_b[k]       = be_b[k] & ~(wr_a & same_addr & be_a[k]);
      new_a[8*k +: 8] = be_a[k] ? din_a[8*k +: 8] : cur_a[8*k +: 8];
      new_b[8*k +: 8] = be_b[k] ? din_b[8*k +: 8] : cur_b[8*k +: 8];
    end
  end

  // Array contents are deliberately not reset; the clear engine zeroes them
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[ptr] <= '0;
    end else begin
      for (int k = 0; k < NB; k++) begin
        if (wr_a && be_a[k]) mem[addr_a][8*k +: 8] <= din_a[8*k +: 8];
        if (wr_b && mask_b[k]) mem[addr_b][8*k +: 8] <= din_b[8*k +: 8];
      end
    end
  end

  // Registered read data; cross-port reads see pre-write contents
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_a <= '0;
      dout_b <= '0;
      vld_a  <= 1'b0;
      vld_b  <= 1'b0;
      coll   <= 1'b0;
    end else begin
      vld_a <= 1'b0;
      vld_b <= 1'b0;
      coll  <= wr_a & wr_b & same_addr;
      if (rd_a) begin
        dout_a <= cur_a;
        vld_a  <= 1'b1;
      end else if (wr_a && RD_MODE == 1) begin
        dout_a <= new_a;
        vld_a  <= 1'b1;
      end
      if (rd_b) begin
        dout_b <= cur_b;
        vld_b  <= 1'b1;
      end else if (wr_b && RD_MODE == 1) begin
        dout_b <= new_b;
        vld_b  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dual_port_ram.sv
// Directed self-checking bench for dual_port_ram: an 8-bit NO_CHANGE instance
// and a 16-bit, non-power-of-2 depth WRITE_FIRST instance share clock and reset.
module tb_dual_port_ram;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en_a, we_a, en_b, we_b, clr;
  logic [0:0] be_a, be_b;
  logic [3:0] addr_a, addr_b;
  logic [7:0] din_a, din_b;
  logic [7:0] dout_a, dout_b;
  logic       vld_a, vld_b, busy, coll;

  logic        en_a1, we_a1;
  logic [1:0]  be_a1;
  logic [3:0]  addr_a1;
  logic [15:0] din_a1, dout_a1, dout_b1;
  logic        vld_a1, vld_b1, busy1, coll1;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  dual_port_ram #(.WIDTH(8), .DEPTH(16), .RD_MODE(0)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .din_a(din_a),
    .dout_a(dout_a), .vld_a(vld_a),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .din_b(din_b),
    .dout_b(dout_b), .vld_b(vld_b),
    .clr(clr), .busy(busy), .coll(coll)
  );

  dual_port_ram #(.WIDTH(16), .DEPTH(10), .RD_MODE(1)) u_wide (
    .clk(clk), .rst_n(rst_n),
    .en_a(en_a1), .we_a(we_a1), .be_a(be_a1), .addr_a(addr_a1), .din_a(din_a1),
    .dout_a(dout_a1), .vld_a(vld_a1),
    .en_b(1'b0), .we_b(1'b0), .be_b(2'b00), .addr_b(4'd0), .din_b(16'h0000),
    .dout_b(dout_b1), .vld_b(vld_b1),
    .clr(1'b0), .busy(busy1), .coll(coll1)
  );

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ports;
    en_a = 1'b0; we_a = 1'b0; be_a = 1'b1; addr_a = 4'd0; din_a = 8'h00;
    en_b = 1'b0; we_b = 1'b0; be_b = 1'b1; addr_b = 4'd0; din_b = 8'h00;
    clr = 1'b0;
    en_a1 = 1'b0; we_a1 = 1'b0; be_a1 = 2'b11; addr_a1 = 4'd0; din_a1 = 16'h0000;
  endtask

  task automatic test_reset;
    int n0, n1;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (busy !== 1'b1 || busy1 !== 1'b1) begin
      tests_failed++; $display("FAIL reset_busy: got %b/%b expected 1/1", busy, busy1);
    end
    tests_run++;
    if (dout_a !== 8'h00 || dout_b !== 8'h00 || vld_a !== 1'b0 || vld_b !== 1'b0 || coll !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got dout %h/%h vld %b/%b coll %b expected 00/00 0/0 0",
               dout_a, dout_b, vld_a, vld_b, coll);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    n0 = 0; n1 = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) n0++;
      if (busy1) n1++;
      cyc();
    end
    tests_run++;
    if (n0 !== 16) begin
      tests_failed++; $display("FAIL reset_clear_len: got %0d expected 16", n0);
    end
    tests_run++;
    if (n1 !== 10) begin
      tests_failed++; $display("FAIL reset_clear_len_d10: got %0d expected 10", n1);
    end
    for (int a = 0; a < 16; a++) begin
      en_a = 1'b1; we_a = 1'b0; addr_a = 4'(a);
      en_b = 1'b1; we_b = 1'b0; addr_b = 4'(15 - a);
      cyc();
      tests_run++;
      if (dout_a !== 8'h00 || vld_a !== 1'b1 || dout_b !== 8'h00 || vld_b !== 1'b1) begin
        tests_failed++;
        $display("FAIL reset_read_zero[%0d]: got %h/%b %h/%b expected 00/1 00/1",
                 a, dout_a, vld_a, dout_b, vld_b);
      end
    end
    idle_ports();
  endtask

  task automatic test_write_read;
    en_a = 1'b1; we_a = 1'b1; addr_a = 4'd3; din_a = 8'hA5; be_a = 1'b1;
    cyc();
    tests_run++;
    if (vld_a !== 1'b0 || dout_a !== 8'h00) begin
      tests_failed++; $display("FAIL wr_no_change: got %h/%b expected 00/0", dout_a, vld_a);
    end
    en_a = 1'b0;
    en_b = 1'b1; we_b = 1'b0; addr_b = 4'd3;
    cyc();
    tests_run++;
    if (dout_b !== 8'hA5 || vld_b !== 1'b1) begin
      tests_failed++; $display("FAIL rd_b_addr3: got %h/%b expected a5/1", dout_b, vld_b);
    end
    en_b = 1'b0;
    en_a = 1'b1; we_a = 1'b0; addr_a = 4'd3;
    cyc();
    tests_run++;
    if (dout_b !== 8'hA5 || vld_b !== 1'b0 || dout_a !== 8'hA5 || vld_a !== 1'b1) begin
      tests_failed++;
      $display("FAIL hold_and_rd_a: got b %h/%b a %h/%b expected a5/0 a5/1", dout_b, vld_b, dout_a, vld_a);
    end
    we_a = 1'b1; addr_a = 4'd0; din_a = 8'h3C;
    cyc();
    tests_run++;
    if (dout_a !== 8'hA5 || vld_a !== 1'b0) begin
      tests_failed++; $display("FAIL rdmode0_write: got %h/%b expected a5/0", dout_a, vld_a);
    end
    we_a = 1'b0;
    cyc();
    tests_run++;
    if (dout_a !== 8'h3C) begin
      tests_failed++; $display("FAIL rd_addr0: got %h expected 3c", dout_a);
    end
    we_a = 1'b1; addr_a = 4'd3; din_a = 8'hFF; be_a = 1'b0;
    cyc();
    we_a = 1'b0; be_a = 1'b1;
    cyc();
    tests_run++;
    if (dout_a !== 8'hA5) begin
      tests_failed++; $display("FAIL be_zero_write: got %h expected a5", dout_a);
    end
    idle_ports();
  endtask

  task automatic test_collision;
    en_a = 1'b1; we_a = 1'b1; addr_a = 4'd7; din_a = 8'h11;
    en_b = 1'b1; we_b = 1'b1; addr_b = 4'd7; din_b = 8'h22;
    cyc();
    tests_run++;
    if (coll !== 1'b1) begin
      tests_failed++; $display("FAIL coll_pulse: got %b expected 1", coll);
    end
    idle_ports();
    cyc();
    tests_run++;
    if (coll !== 1'b0) begin
      tests_failed++; $display("FAIL coll_one_cycle: got %b expected 0", coll);
    end
    en_a = 1'b1; addr_a = 4'd7;
    cyc();
    tests_run++;
    if (dout_a !== 8'h11) begin
      tests_failed++; $display("FAIL coll_a_wins: got %h expected 11", dout_a);
    end
    en_a = 1'b1; we_a = 1'b1; addr_a = 4'd8; din_a = 8'h33; be_a = 1'b0;
    en_b = 1'b1; we_b = 1'b1; addr_b = 4'd8; din_b = 8'h44; be_b = 1'b1;
    cyc();
    tests_run++;
    if (coll !== 1'b1) begin
      tests_failed++; $display("FAIL coll_be_zero: got %b expected 1", coll);
    end
    idle_ports();
    en_a = 1'b1; addr_a = 4'd8;
    cyc();
    tests_run++;
    if (dout_a !== 8'h44 || coll !== 1'b0) begin
      tests_failed++; $display("FAIL coll_b_byte: got %h/%b expected 44/0", dout_a, coll);
    end
    we_a = 1'b1; addr_a = 4'd2; din_a = 8'h5A;
    cyc();
    din_a = 8'h77;
    en_b = 1'b1; we_b = 1'b0; addr_b = 4'd2;
    cyc();
    tests_run++;
    if (dout_b !== 8'h5A || vld_b !== 1'b1) begin
      tests_failed++; $display("FAIL cross_rd_old: got %h/%b expected 5a/1", dout_b, vld_b);
    end
    en_a = 1'b0;
    cyc();
    tests_run++;
    if (dout_b !== 8'h77) begin
      tests_failed++; $display("FAIL cross_rd_new: got %h expected 77", dout_b);
    end
    en_a = 1'b1; we_a = 1'b1; addr_a = 4'd9;  din_a = 8'h99;
    en_b = 1'b1; we_b = 1'b1; addr_b = 4'd10; din_b = 8'hAA;
    cyc();
    tests_run++;
    if (coll !== 1'b0) begin
      tests_failed++; $display("FAIL dual_wr_no_coll: got %b expected 0", coll);
    end
    we_a = 1'b0; addr_a = 4'd10;
    we_b = 1'b0; addr_b = 4'd9;
    cyc();
    tests_run++;
    if (dout_a !== 8'hAA || dout_b !== 8'h99 || coll !== 1'b0) begin
      tests_failed++; $display("FAIL dual_rd: got %h %h %b expected aa 99 0", dout_a, dout_b, coll);
    end
    idle_ports();
  endtask

  task automatic test_wide;
    en_a1 = 1'b1; we_a1 = 1'b1; addr_a1 = 4'd5; din_a1 = 16'hFFFF; be_a1 = 2'b11;
    cyc();
    tests_run++;
    if (dout_a1 !== 16'hFFFF || vld_a1 !== 1'b1) begin
      tests_failed++; $display("FAIL wf_full: got %h/%b expected ffff/1", dout_a1, vld_a1);
    end
    din_a1 = 16'h1234; be_a1 = 2'b01;
    cyc();
    tests_run++;
    if (dout_a1 !== 16'hFF34 || vld_a1 !== 1'b1) begin
      tests_failed++; $display("FAIL wf_merge: got %h/%b expected ff34/1", dout_a1, vld_a1);
    end
    we_a1 = 1'b0;
    cyc();
    tests_run++;
    if (dout_a1 !== 16'hFF34 || vld_a1 !== 1'b1) begin
      tests_failed++; $display("FAIL wide_rd: got %h/%b expected ff34/1", dout_a1, vld_a1);
    end
    we_a1 = 1'b1; addr_a1 = 4'd0; din_a1 = 16'h003C; be_a1 = 2'b11;
    cyc();
    tests_run++;
    if (dout_a1 !== 16'h003C || vld_a1 !== 1'b1) begin
      tests_failed++; $display("FAIL wf_addr0: got %h/%b expected 003c/1", dout_a1, vld_a1);
    end
    addr_a1 = 4'd9; din_a1 = 16'hBEEF; be_a1 = 2'b10;
    cyc();
    we_a1 = 1'b0;
    cyc();
    tests_run++;
    if (dout_a1 !== 16'hBE00) begin
      tests_failed++; $display("FAIL wide_last_addr: got %h expected be00", dout_a1);
    end
    en_a1 = 1'b0;
    cyc();
    tests_run++;
    if (dout_a1 !== 16'hBE00 || vld_a1 !== 1'b0) begin
      tests_failed++; $display("FAIL wide_hold: got %h/%b expected be00/0", dout_a1, vld_a1);
    end
    idle_ports();
  endtask

  task automatic test_clear;
    int  n;
    logic vld_seen;
    en_a = 1'b1; addr_a = 4'd3;
    cyc();
    idle_ports();
    clr = 1'b1;
    cyc();
    n = 0; vld_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy) n++;
      clr  = (i == 5);
      en_a = (i == 3 || i == 6); we_a = 1'b0; addr_a = 4'd3;
      en_b = (i == 4);           we_b = 1'b1; addr_b = 4'd7; din_b = 8'hEE;
      cyc();
      if (vld_a || vld_b) vld_seen = 1'b1;
    end
    idle_ports();
    tests_run++;
    if (n !== 16) begin
      tests_failed++; $display("FAIL clr_len: got %0d expected 16", n);
    end
    tests_run++;
    if (vld_seen !== 1'b0 || dout_a !== 8'hA5) begin
      tests_failed++; $display("FAIL clr_blocks_access: got vld %b dout %h expected 0 a5", vld_seen, dout_a);
    end
    for (int a = 0; a < 16; a++) begin
      en_a = 1'b1; addr_a = 4'(a);
      cyc();
      tests_run++;
      if (dout_a !== 8'h00 || vld_a !== 1'b1) begin
        tests_failed++; $display("FAIL clr_zero[%0d]: got %h/%b expected 00/1", a, dout_a, vld_a);
      end
    end
    idle_ports();
  endtask

  task automatic test_reset_mid_clear;
    int n;
    en_a = 1'b1; we_a = 1'b1; addr_a = 4'd12; din_a = 8'h4D;
    cyc();
    we_a = 1'b0;
    cyc();
    idle_ports();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    repeat (8) cyc();
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (dout_a !== 8'h00 || busy !== 1'b1 || vld_a !== 1'b0) begin
      tests_failed++; $display("FAIL mid_clear_reset: got %h/%b/%b expected 00/1/0", dout_a, busy, vld_a);
    end
    cyc();
    cyc();
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) n++;
      cyc();
    end
    tests_run++;
    if (n !== 16) begin
      tests_failed++; $display("FAIL restart_len: got %0d expected 16", n);
    end
    en_a = 1'b1; addr_a = 4'd12;
    cyc();
    tests_run++;
    if (dout_a !== 8'h00 || vld_a !== 1'b1) begin
      tests_failed++; $display("FAIL restart_cleared: got %h/%b expected 00/1", dout_a, vld_a);
    end
    idle_ports();
  endtask

  initial begin
    idle_ports();
    test_reset();
    test_write_read();
    test_collision();
    test_wide();
    test_clear();
    test_reset_mid_clear();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dual_port_ram.md
DUAL_PORT_RAM -- requirements
Module: dual_port_ram

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width in bits; SHALL be a multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 16: number of words; SHALL be at least 2.
REQ-003 SHALL have parameter RD_MODE, default 0: same-port write behaviour; 0 = NO_CHANGE, 1 = WRITE_FIRST.
REQ-004 SHALL define NB = WIDTH/8 and AW = $clog2(DEPTH) as local constants.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 en_a / en_b  input  1  port access request.
REQ-008 we_a / we_b  input  1  1 = write, 0 = read; meaningful only with en.
REQ-009 be_a / be_b  input  NB  byte write enables; bit k covers data bits [8k+7:8k].
REQ-010 addr_a / addr_b  input  AW  word address.
REQ-011 din_a / din_b  input  WIDTH  write data.
REQ-012 dout_a / dout_b  output  WIDTH  registered read data.
REQ-013 vld_a / vld_b  output  1  dout updated this cycle (one-cycle pulse).
REQ-014 clr  input  1  request a full-array zero clear.
REQ-015 busy  output  1  clear engine active; port accesses are ignored.
REQ-016 coll  output  1  one-cycle pulse on same-address dual write.

Function
REQ-017 Controller FSM SHALL have two states: CLEAR and IDLE.
REQ-018 In CLEAR, the FSM SHALL write zero to mem[ptr] each cycle, with ptr starting at 0 and incrementing by 1.
REQ-019 In CLEAR with ptr==DEPTH-1, the FSM SHALL write the last word and go to IDLE; the clear lasts exactly DEPTH cycles.
REQ-020 busy SHALL be 1 exactly while the state is CLEAR.
REQ-021 In IDLE, clr=1 SHALL enter CLEAR with ptr=0 at the next edge.
REQ-022 clr while busy SHALL be ignored; no restart and no extension.
REQ-023 While busy, en_a and en_b SHALL be ignored: no memory write, no dout change, vld=0.
REQ-024 In IDLE, a read (en=1, we=0) SHALL load dout with mem[addr] at the edge and assert vld for that one cycle; read latency is 1.
REQ-025 In IDLE, a write (en=1, we=1) SHALL update only the bytes whose be bit is 1.
REQ-026 A write with be all zero SHALL leave memory unchanged; it still counts as a write for REQ-027.
REQ-027 On a same-port write, dout and vld SHALL follow RD_MODE:
  - RD_MODE=0: dout holds and vld=0.
  - RD_MODE=1: dout = merged word (new enabled bytes, old other bytes) and vld=1.
REQ-028 With no access, dout SHALL hold its value and vld SHALL be 0.
REQ-029 A cross-port read of an address the other port writes in the same cycle SHALL return the old (pre-write) data.
REQ-030 If both ports write the same address in the same cycle:
  - port A SHALL win per byte wherever be_a is set;
  - port B bytes SHALL apply only where be_a=0 and be_b=1;
  - coll SHALL pulse for one cycle.
REQ-031 Dual writes to different addresses, and dual reads of any addresses, SHALL both complete with no coll.
REQ-032 No arithmetic overflow SHALL occur on addresses; all addr values below DEPTH are legal, and addr>=DEPTH is undefined (non-power-of-2 DEPTH).

Reset
REQ-033 rst_n=0 SHALL asynchronously force dout_a=dout_b=0, vld_a=vld_b=0, coll=0, ptr=0, state=CLEAR, busy=1.
REQ-034 After rst_n rises, the FSM SHALL run the full DEPTH-cycle clear, then enter IDLE; memory contents are not reset asynchronously.
REQ-035 Reset asserted mid-clear or mid-access SHALL abort that operation and restart the clear from ptr=0.

Verification
REQ-036 Reset release with DEPTH=16 -> busy=1 for exactly 16 cycles; a read of every address afterwards returns 0 with vld pulses.
REQ-037 Port A writes 0xA5 to addr 3 (be=1), then port B reads addr 3 -> dout_b=0xA5 and vld_b=1 one cycle after the read request.
REQ-038 WIDTH=16, port A writes 0x1234 to addr 5 with be=2'b01 over 0xFFFF -> a read returns 0xFF34.
REQ-039 Both ports write addr 7 in the same cycle, A=0x11 be=1 and B=0x22 be=1 -> mem[7]=0x11 and coll pulses once; A writes addr 2 while B reads addr 2 in the same cycle -> B gets the old value.
REQ-040 RD_MODE=1 port A write 0x3C to addr 0 -> dout_a=0x3C with vld_a=1; RD_MODE=0 -> dout_a unchanged and vld_a=0.
REQ-041 clr pulse in IDLE, a second clr pulse at cycle 5, and a read issued while busy -> exactly DEPTH busy cycles, no vld, all words 0; rst_n pulsed at cycle 8 of a clear -> clear restarts with a full DEPTH count.
